// File: rtl/intlv_frame_sched.sv
// Frame sequencer for the turbo interleaver RAM: command FIFO, link-ID lookup, write/gap/read phases.
// Optional FRAME_STAT_EN adds saturating completed-frame and dropped-command counters.
module intlv_frame_sched #(
    parameter int CMD_DEPTH = 4,
    parameter int GAP_CYC   = 2,
    parameter int LEN_W     = 13
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_vld,
    input  logic [5:0]       cmd_link_id,
    output logic             cmd_rdy,
    output logic [LEN_W-1:0] m_len,
    output logic             din_vld,
    output logic             src_rdy,
    input  logic             dn_rdy,
    output logic             request,
    output logic             busy,
    output logic             frame_done,
    output logic             cmd_err,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, READ, DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]       fifo_mem [CMD_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop, fifo_empty;
    logic [5:0]       head_id;
    logic             id_ok;
    logic [LEN_W-1:0] id_len;
    logic [LEN_W-1:0] wr_cnt, rd_cnt, last_idx;
    logic [GW-1:0]    gap_cnt;

    assign cmd_rdy    = (count != CW'(CMD_DEPTH));
    assign push       = cmd_vld && cmd_rdy;
    assign pop        = (state == LOAD);
    assign fifo_empty = (count == '0);
    assign head_id    = fifo_mem[rd_ptr];
    assign last_idx   = m_len - LEN_W'(1);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= cmd_link_id;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_comb begin
        id_ok  = 1'b1;
        id_len = '0;
        case (head_id)
            6'd25:   id_len = LEN_W'(4776);
            6'd26:   id_len = LEN_W'(5456);
            6'd27:   id_len = LEN_W'(6032);
            6'd28:   id_len = LEN_W'(5280);
            6'd29:   id_len = LEN_W'(5552);
            6'd32:   id_len = LEN_W'(312);
            6'd33:   id_len = LEN_W'(4280);
            6'd34:   id_len = LEN_W'(4160);
            default: id_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        din_vld    = 1'b0;
        src_rdy    = 1'b0;
        request    = 1'b0;
        frame_done = 1'b0;
        cmd_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (id_ok) begin
                    state_nxt = WRITE;
                end else begin
                    cmd_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                src_rdy = 1'b1;
                din_vld = (wr_cnt == '0);
                if (wr_cnt == last_idx)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1))
                    state_nxt = READ;
            end
            READ: begin
                request = dn_rdy;
                if (dn_rdy && rd_cnt == last_idx)
                    state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = fifo_empty ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // m_len only moves in LOAD, so queued commands never disturb a running frame
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            m_len   <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                gap_cnt <= '0;
                if (id_ok)
                    m_len <= id_len;
            end
            if (state == WRITE)
                wr_cnt <= wr_cnt + LEN_W'(1);
            if (state == GAP)
                gap_cnt <= gap_cnt + GW'(1);
            if (state == READ && dn_rdy)
                rd_cnt <= rd_cnt + LEN_W'(1);
        end
    end

`ifdef FRAME_STAT_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done && frame_cnt_q != 16'hFFFF)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (cmd_err && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_intlv_frame_sched.sv
// Scoreboard bench for intlv_frame_sched: expected frame lengths queued on command accept,
// checked against m_len, write/read strobe counts and timing at each frame_done.
module tb_intlv_frame_sched;

    localparam int GAP = 2;
`ifdef FRAME_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cmd_vld = 1'b0;
    logic [5:0]  cmd_link_id = '0;
    logic        cmd_rdy;
    logic [12:0] m_len;
    logic        din_vld, src_rdy, request, busy, frame_done, cmd_err;
    logic        dn_rdy = 1'b1;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    intlv_frame_sched #(.CMD_DEPTH(4), .GAP_CYC(GAP), .LEN_W(13)) dut (
        .clk(clk), .n_rst(n_rst), .cmd_vld(cmd_vld), .cmd_link_id(cmd_link_id),
        .cmd_rdy(cmd_rdy), .m_len(m_len), .din_vld(din_vld), .src_rdy(src_rdy),
        .dn_rdy(dn_rdy), .request(request), .busy(busy), .frame_done(frame_done),
        .cmd_err(cmd_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int len_of(input logic [5:0] id);
        case (id)
            6'd25: return 4776;
            6'd26: return 5456;
            6'd27: return 6032;
            6'd28: return 5280;
            6'd29: return 5552;
            6'd32: return 312;
            6'd33: return 4280;
            6'd34: return 4160;
            default: return -1;
        endcase
    endfunction

    logic [12:0] exp_q[$];
    int done_q[$];

    bit dn_tog = 0;
    bit dn_lvl = 1;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dn_rdy = dn_tog ? ~dn_rdy : dn_lvl;
        end
    end

    int src_cnt, first_src, last_src;
    int req_cnt, first_req, last_req, bad_req;
    int din_cnt, din_cyc, din_last, last_dur;
    int err_seen = 0;
    int done_cnt = 0;
    int last_done = 0;
    bit gap_chk = 1;
    bit b2b_chk = 0;
    int b2b_base = 0;

    task automatic clr_frame();
        src_cnt = 0; first_src = 0; last_src = 0;
        req_cnt = 0; first_req = 0; last_req = 0; bad_req = 0;
        din_cnt = 0; din_cyc = 0;
    endtask

    initial clr_frame();

    always @(negedge clk) begin
        if (!n_rst) begin
            clr_frame();
        end else begin
            if (din_vld) begin
                din_cnt++;
                din_cyc  = cyc;
                din_last = cyc;
                if (b2b_chk && done_cnt >= b2b_base)
                    chk("b2b_din", cyc - last_done, 2);
            end
            if (src_rdy) begin
                if (src_cnt == 0) first_src = cyc;
                src_cnt++;
                last_src = cyc;
            end
            if (request) begin
                if (req_cnt == 0) first_req = cyc;
                req_cnt++;
                last_req = cyc;
                if (!dn_rdy) bad_req++;
            end
            if (cmd_err) err_seen++;
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    chk("m_len", m_len, e);
                    chk("src_n", src_cnt, e);
                    chk("src_run", last_src - first_src + 1, src_cnt);
                    chk("req_n", req_cnt, e);
                    chk("din_n", din_cnt, 1);
                    chk("din_pos", din_cyc, first_src);
                    chk("done_pos", cyc - last_req, 1);
                    chk("bad_req", bad_req, 0);
                    if (gap_chk)
                        chk("gap", first_req - last_src, GAP + 1);
                end
                last_dur  = cyc - din_cyc;
                last_done = cyc;
                done_q.push_back(cyc);
                done_cnt++;
                clr_frame();
            end
        end
    end

    task automatic send_cmd(input logic [5:0] id, output int acc);
        bit ok;
        ok  = 0;
        acc = -1;
        cmd_vld = 1'b1;
        cmd_link_id = id;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                ok  = 1;
                acc = cyc;
                if (len_of(id) > 0)
                    exp_q.push_back(13'(len_of(id)));
            end
            @(posedge clk);
            #1;
        end
        cmd_vld = 1'b0;
        chk("cmd_acc", ok, 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 30000 && done_cnt < target; i++)
            @(negedge clk);
        @(posedge clk);
        #1;
        chk(tag, done_cnt, target);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, cmd_rdy, 1);
        chk({tag, "_mlen"}, m_len, 0);
        chk({tag, "_din"}, din_vld, 0);
        chk({tag, "_src"}, src_rdy, 0);
        chk({tag, "_req"}, request, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_err"}, cmd_err, 0);
        chk({tag, "_fcnt"}, frame_cnt, 0);
        chk({tag, "_ecnt"}, err_cnt, 0);
    endtask

    initial begin
        int acc, acc6, base, ebase;
        bit busy_seen;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // single link-32 frame with continuous downstream ready
        send_cmd(6'd32, acc);
        wait_done(1, "t1_done");
        chk("t1_lat", din_last - acc, 3);
        chk("t1_dur", last_dur, 2 * 312 + GAP);
        chk("t1_mlen_hold", m_len, 13'h0138);

        // link 25 with dn_rdy toggling every cycle
        gap_chk = 0;
        dn_tog  = 1;
        send_cmd(6'd25, acc);
        wait_done(2, "t2_done");
        dn_tog  = 0;
        dn_lvl  = 1;
        gap_chk = 1;

        // unsupported ID followed by a valid one
        ebase = err_seen;
        send_cmd(6'd30, acc);
        send_cmd(6'd33, acc);
        wait_done(3, "t3_done");
        chk("t3_err", err_seen - ebase, 1);
        chk("t3_ecnt", err_cnt, STAT);
        chk("t3_mlen", m_len, 13'h10B8);

        // six queued commands against a 4-deep FIFO
        base = done_q.size();
        b2b_base = done_cnt + 1;
        b2b_chk = 1;
        send_cmd(6'd34, acc);
        for (int i = 0; i < 100 && !busy; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send_cmd(6'd32, acc);
        send_cmd(6'd34, acc);
        send_cmd(6'd32, acc);
        send_cmd(6'd34, acc);
        @(negedge clk);
        chk("t4_full", cmd_rdy, 0);
        @(posedge clk);
        #1;
        send_cmd(6'd32, acc6);
        chk("t4_pop", acc6 - (done_q.size() > base ? done_q[base] : -100), 2);
        wait_done(9, "t4_done");
        b2b_chk = 0;
        chk("t4_fcnt", frame_cnt, 9 * STAT);

        // reset during the read phase of link 27, with a command still queued
        send_cmd(6'd27, acc);
        for (int i = 0; i < 20000 && !request; i++)
            @(negedge clk);
        chk("t5_read", request, 1);
        @(posedge clk);
        #1;
        send_cmd(6'd25, acc);
        base = done_cnt;
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset("t5_async");
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk_reset("t5_hold");
        n_rst = 1'b1;
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        chk("t5_idle", busy_seen, 0);
        chk("t5_nodone", done_cnt, base);
        @(posedge clk);
        #1;

        // clean link-26 frame after the abort
        send_cmd(6'd26, acc);
        wait_done(base + 1, "t6_done");
        chk("t6_mlen", m_len, 13'h1550);
        chk("t6_fcnt", frame_cnt, STAT);
        chk("t6_ecnt", err_cnt, 0);
        chk("sb_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/intlv_frame_sched.md
Name: intlv_frame_sched

Overview:
- Frame-level sequencer for the SAT-downlink turbo interleaver RAM.
- Accepts queued link-ID commands, maps each to its frame length m_len, then runs two phases per frame:
  - write phase: start pulse plus data window towards the enable generator and RAM;
  - read phase: request strobes gated by downstream ready.
- Serialises frames so that only one frame occupies the interleaver RAM at a time.

Parameters:
- CMD_DEPTH, 4, command FIFO depth in entries (power of 2, at least 2).
- GAP_CYC, 2, idle cycles between the last write and the first read (RAM turnaround), at least 1.
- LEN_W, 13, width of m_len.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_link_id  in  6  link ID of the command.
- cmd_rdy  out  1  FIFO not full; a command is accepted when cmd_vld && cmd_rdy.
- m_len  out  LEN_W  frame length of the current frame; held stable from LOAD until the next LOAD.
- din_vld  out  1  one-cycle start pulse to the enable generator.
- src_rdy  out  1  write window; upstream supplies one word per cycle while high.
- dn_rdy  in  1  downstream can accept a read word.
- request  out  1  read strobe to the enable generator.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- cmd_err  out  1  one-cycle pulse when an unsupported link ID is dropped.
- frame_cnt  out  16  completed-frame count (see Optional Feature).
- err_cnt  out  8  dropped-command count (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs are 0, except cmd_rdy, which is 1 (FIFO empty).
  - FSM returns to IDLE, FIFO is emptied, counters are cleared.
  - Reset asserted mid-frame aborts the frame immediately; no frame_done is produced.
- Link-ID table (decimal length, hex):
  - 25 -> 4776 (0x12A8)
  - 26 -> 5456 (0x1550)
  - 27 -> 6032 (0x1790)
  - 28 -> 5280 (0x14A0)
  - 29 -> 5552 (0x15B0)
  - 32 -> 312 (0x0138)
  - 33 -> 4280 (0x10B8)
  - 34 -> 4160 (0x1040)
  - Every other ID, including 30 and 31, is unsupported.
- Command FIFO:
  - cmd_rdy = (count != CMD_DEPTH), derived from registered count only; no full-bypass.
  - A push and a pop in the same cycle leave count unchanged.
- FSM states: IDLE, LOAD, WRITE, GAP, READ, DONE.
- IDLE: moves to LOAD when the FIFO is not empty.
- LOAD (1 cycle):
  - Pops the FIFO head.
  - Valid ID: registers m_len; next state WRITE.
  - Invalid ID: cmd_err pulses, m_len is unchanged; next state IDLE.
- WRITE:
  - din_vld=1 on the first WRITE cycle only.
  - src_rdy=1 for exactly m_len consecutive cycles, starting with the din_vld cycle.
  - wr_cnt counts 0 to m_len-1; leaving WRITE occurs when wr_cnt == m_len-1.
  - No backpressure in the write phase.
- GAP: exactly GAP_CYC cycles with all strobes low, then READ.
- READ:
  - request = dn_rdy (combinational AND with state == READ).
  - rd_cnt increments on each request cycle.
  - After the request with rd_cnt == m_len-1, next state DONE.
  - dn_rdy low stalls the read with no timeout.
- DONE (1 cycle): frame_done=1; next state LOAD if the FIFO is not empty, else IDLE.
- Latency:
  - cmd accept to din_vld is 3 cycles when idle (FIFO write, IDLE, LOAD).
  - Frame length = 1 (LOAD) + m_len + GAP_CYC + m_len (+ stall cycles) + 1 (DONE).
- Counters:
  - wr_cnt and rd_cnt are LEN_W bits wide and cleared in LOAD.
  - Comparisons are done at LEN_W width; no wrap is possible because the terminal count ends the phase.
- Commands arriving during a frame are queued and never affect the current m_len.
- Width rule: m_len is zero-extended when compared against wider counters downstream.

Optional Feature:
- Macro FRAME_STAT_EN.
- Defined:
  - frame_cnt increments on each frame_done and saturates at 0xFFFF.
  - err_cnt increments on each cmd_err and saturates at 0xFF.
  - Both are cleared only by reset.
- Not defined: frame_cnt and err_cnt are tied to 0 and no counter flops are instantiated; ports remain for interface stability.

Test Plan:
- Single command, link 32, dn_rdy=1:
  - din_vld at cycle T; src_rdy high for 312 cycles.
  - 2 idle cycles, then request high for 312 cycles.
  - frame_done at T+312+2+312; m_len reads 0x0138.
- Link 25 with dn_rdy toggling 1/0 every cycle:
  - exactly 4776 request pulses, never asserted while dn_rdy=0.
  - frame_done one cycle after the 4776th request.
- Push IDs 30 then 33 back-to-back:
  - cmd_err pulses once; m_len=0x10B8 for the frame that follows.
  - one frame_done; err_cnt=1 with FRAME_STAT_EN defined, 0 without.
- Push 6 commands (alternating 34 and 32) while busy with CMD_DEPTH=4:
  - cmd_rdy low when 4 are queued.
  - the 6th command is accepted only after a pop.
  - 6 frame_done pulses total, in order, with m_len alternating 0x1040 and 0x0138.
- Assert n_rst during the READ phase of link 27:
  - all outputs return to reset values immediately, FIFO is empty, no frame_done.
  - a following link 26 command runs a clean frame with m_len=0x1550.
- Back-to-back queued frames:
  - DONE proceeds directly to LOAD (no IDLE cycle).
  - din_vld of the second frame comes 2 cycles after the first frame_done.
